ansi_cmd_parser: RTL and testbench
==================================

Name: ansi_cmd_parser

Overview:
- Sits between uart_rx and the framebuffer write state machine in the terminal top.
- Buffers received bytes, decodes plain characters, C0 controls and a subset of ANSI/VT100 CSI escape sequences.
- Emits one decoded terminal command at a time over a valid/ready handshake.
- The writer then only places characters and moves the cursor; it no longer inspects raw bytes.

Parameters:
- COLS, 80, screen width in characters; clamps column arguments.
- ROWS, 30, screen height in characters; clamps row arguments.
- FIFO_DEPTH, 4, input byte FIFO depth; power of two, minimum 2.
- MAX_PARAM, 99, saturation value for decimal CSI parameters.

Ports:
- clk  input  1  system clock (25 MHz pixel clock domain).
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  byte from uart_rx.
- rx_valid  input  1  single-cycle strobe; rx_data is valid in that cycle. No backpressure.
- cmd_valid  output  1  a command is presented.
- cmd_ready  input  1  the writer accepts the command.
- cmd_op  output  4  0 PUTC, 1 CR, 2 LF, 3 BS, 4 CUP, 5 ED, 6 EL, 7 MOVE, 8 SGR.
- cmd_char  output  8  PUTC: the character; MOVE: direction letter 'A'/'B'/'C'/'D'; otherwise 0.
- cmd_arg0  output  7  CUP: row (0-based); MOVE: count; SGR: first parameter; otherwise 0.
- cmd_arg1  output  7  CUP: column (0-based); otherwise 0.
- overflow  output  1  sticky flag: an input byte was dropped.

Behaviour:
- Reset (asynchronous, immediate): FIFO empty, parser in GROUND, params cleared. cmd_valid, cmd_op, cmd_char, cmd_arg0, cmd_arg1 and overflow are all 0. Reset mid-sequence discards the partial sequence.
- FIFO write: on rx_valid when not full.
- FIFO full with no pop in the same cycle: the byte is dropped and overflow is set. overflow clears only on reset.
- FIFO full with a pop in the same cycle: the write succeeds.
- Pop rule: the parser pops one byte per cycle when FIFO is non-empty AND (cmd_valid==0 OR cmd_ready==1).
- Latency: a printable byte strobed in cycle t into an empty FIFO with an idle output gives cmd_valid=1 in cycle t+2. Sustained throughput is 1 byte/cycle.
- Handshake: once cmd_valid rises, cmd_valid and all cmd_* fields hold stable until a cycle with cmd_ready=1. A new command may replace the old one on that same edge.
- GROUND state:
  - 0x20-0x7E -> PUTC.
  - 0x0D -> CR.
  - 0x0A -> LF.
  - 0x08 -> BS.
  - 0x1B -> ESC state.
  - All other bytes, including 0x7F, are dropped.
- ESC state:
  - '[' -> CSI state; clear params, index=0, have-digit flags=0.
  - 0x1B -> stay in ESC.
  - Any other byte -> GROUND, no command.
- CSI state:
  - '0'-'9': param[index] = param*10 + digit, saturating at MAX_PARAM.
  - ';': index++. Digits for index >= 2 are ignored.
  - 0x18 or 0x1A -> GROUND, no command.
  - 0x1B -> ESC.
  - Other bytes 0x00-0x2F and 0x3A-0x3F (except ';') are ignored.
  - A final byte 0x40-0x7E dispatches the command, then returns to GROUND.
- Dispatch:
  - 'H' or 'f' -> CUP. Missing or zero param counts as 1. row = min(p0,ROWS)-1, col = min(p1,COLS)-1.
  - 'A'/'B'/'C'/'D' -> MOVE. arg0 = p0, where a missing or zero value counts as 1. cmd_char = the final byte.
  - 'J' with p0==2 -> ED. Any other p0 -> no command.
  - 'K' with p0 missing or 0 -> EL. Any other p0 -> no command.
  - All other final bytes -> no command.
- A sequence that produces no command consumes its bytes without asserting cmd_valid.
- Width: parameter arithmetic is done in 7 bits. The multiply-by-10 check is made before the store so results never wrap.

Optional Feature:
- Macro: ANSI_SGR_EN.
- Defined: final byte 'm' emits SGR with arg0 = p0, where missing counts as 0. arg1 = p1 if present, else 0.
- Undefined: 'm' sequences are consumed silently, and op 8 is never emitted.

Test Plan:
- Reset, then strobe "A", 0x0D, 0x0A with cmd_ready=1 -> commands in order: PUTC/0x41, CR, LF. First cmd_valid appears 2 cycles after the 'A' strobe.
- "ESC[12;40H" -> one CUP, arg0=11, arg1=39. "ESC[H" -> CUP 0,0. "ESC[99;200H" -> CUP 29,79.
- "ESC[5C", "ESC[D", "ESC[2J", "ESC[K", "ESC[1J" -> MOVE 'C' count 5, MOVE 'D' count 1, ED, EL, then nothing for the last.
- cmd_ready=0 with 6 back-to-back strobes "abcdef" -> first command holds stable. FIFO absorbs 4 bytes, 1 byte is dropped, overflow=1. Releasing cmd_ready yields a, b, c, d, e in order, and overflow stays 1.
- "ESC[3" followed by 0x18, then "x" -> only PUTC 'x'. Assert reset during "ESC[1" then send "2H" -> PUTC '2', PUTC 'H'.
- With ANSI_SGR_EN, "ESC[32m" -> SGR arg0=32, arg1=0. Without it -> no command emitted.

Source files
------------

// File: rtl/ansi_cmd_parser.sv
// ansi_cmd_parser: byte FIFO plus a GROUND/ESC/CSI decoder that turns the
// uart_rx byte stream into one terminal command at a time on a valid/ready
// output register.
// Optional feature macro: ANSI_SGR_EN. When it is defined, CSI 'm' emits SGR (op 8).
// When it is not defined, 'm' sequences are consumed silently.
//
// state  | meaning
// GROUND | plain characters and C0 controls
// ESC    | ESC seen, waiting for '['
// CSI    | collecting decimal parameters until a final byte
module ansi_cmd_parser #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_PARAM  = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [3:0] cmd_op,
    output logic [7:0] cmd_char,
    output logic [6:0] cmd_arg0,
    output logic [6:0] cmd_arg1,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {GROUND, ESC, CSI} state_t;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push;
    logic [7:0]  cur;

    state_t      state, next_state;
    logic [6:0]  p0, p1;
    logic [1:0]  idx;

    logic        emit;
    logic [3:0]  dec_op;
    logic [7:0]  dec_char;
    logic [6:0]  dec_arg0, dec_arg1;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // The parser only stalls while a presented command is not being taken.
    assign pop   = !empty && (!cmd_valid || cmd_ready);
    // A pop in the same cycle frees the slot, so a write into a full FIFO still succeeds.
    assign push  = rx_valid && (!full || pop);
    assign cur   = mem[rd_ptr[AW-1:0]];

    // Decimal accumulate with saturation; the overflow test is done before the store.
    function automatic logic [6:0] acc_digit(input logic [6:0] p, input logic [3:0] d);
        logic [6:0] t;
        if (int'(p) > MAX_PARAM / 10) return 7'(MAX_PARAM);
        t = p * 7'd10;
        if (int'(t) + int'(d) > MAX_PARAM) return 7'(MAX_PARAM);
        return t + {3'b000, d};
    endfunction

    // Missing or zero counts as 1, then clamp to the screen size and make 0-based.
    function automatic logic [6:0] pos_arg(input logic [6:0] p, input int lim);
        logic [6:0] v;
        v = (p == 7'd0) ? 7'd1 : p;
        if (int'(v) > lim) v = 7'(lim);
        return v - 7'd1;
    endfunction

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
    end

    // FIFO pointers and the sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (rx_valid && !push) overflow <= 1'b1;
        end
    end

    // Parser state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= GROUND;
        else       state <= next_state;
    end

    // Next-state decode, advanced only when a byte is popped.
    always_comb begin
        next_state = state;
        if (pop) begin
            case (state)
                GROUND: if (cur == 8'h1B) next_state = ESC;
                ESC: begin
                    if (cur == 8'h5B)      next_state = CSI;
                    else if (cur == 8'h1B) next_state = ESC;
                    else                   next_state = GROUND;
                end
                CSI: begin
                    if (cur == 8'h18 || cur == 8'h1A)      next_state = GROUND;
                    else if (cur == 8'h1B)                 next_state = ESC;
                    else if (cur >= 8'h40 && cur <= 8'h7E) next_state = GROUND;
                end
                default: next_state = GROUND;
            endcase
        end
    end

    // CSI parameter collection; indices past 1 are counted but their digits ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0  <= '0;
            p1  <= '0;
            idx <= '0;
        end else if (pop) begin
            if (state == ESC && cur == 8'h5B) begin
                p0  <= '0;
                p1  <= '0;
                idx <= '0;
            end else if (state == CSI) begin
                if (cur >= 8'h30 && cur <= 8'h39) begin
                    if (idx == 2'd0)      p0 <= acc_digit(p0, cur[3:0]);
                    else if (idx == 2'd1) p1 <= acc_digit(p1, cur[3:0]);
                end else if (cur == 8'h3B && idx != 2'd2) begin
                    idx <= idx + 2'd1;
                end
            end
        end
    end

    // Command decode for the byte at the FIFO head.
    always_comb begin
        emit     = 1'b0;
        dec_op   = 4'd0;
        dec_char = 8'h00;
        dec_arg0 = 7'd0;
        dec_arg1 = 7'd0;
        if (state == GROUND) begin
            if (cur >= 8'h20 && cur <= 8'h7E) begin
                emit     = 1'b1;
                dec_char = cur;
            end else if (cur == 8'h0D) begin
                emit   = 1'b1;
                dec_op = 4'd1;
            end else if (cur == 8'h0A) begin
                emit   = 1'b1;
                dec_op = 4'd2;
            end else if (cur == 8'h08) begin
                emit   = 1'b1;
                dec_op = 4'd3;
            end
        end else if (state == CSI) begin
            case (cur)
                8'h48, 8'h66: begin
                    emit     = 1'b1;
                    dec_op   = 4'd4;
                    dec_arg0 = pos_arg(p0, ROWS);
                    dec_arg1 = pos_arg(p1, COLS);
                end
                8'h41, 8'h42, 8'h43, 8'h44: begin
                    emit     = 1'b1;
                    dec_op   = 4'd7;
                    dec_char = cur;
                    dec_arg0 = (p0 == 7'd0) ? 7'd1 : p0;
                end
                8'h4A: begin
                    emit   = (p0 == 7'd2);
                    dec_op = 4'd5;
                end
                8'h4B: begin
                    emit   = (p0 == 7'd0);
                    dec_op = 4'd6;
                end
`ifdef ANSI_SGR_EN
                8'h6D: begin
                    emit     = 1'b1;
                    dec_op   = 4'd8;
                    dec_arg0 = p0;
                    dec_arg1 = p1;
                end
`endif
                default: emit = 1'b0;
            endcase
        end
    end

    // Output register: holds until accepted, may be replaced on the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_char  <= '0;
            cmd_arg0  <= '0;
            cmd_arg1  <= '0;
        end else if (pop && emit) begin
            cmd_valid <= 1'b1;
            cmd_op    <= dec_op;
            cmd_char  <= dec_char;
            cmd_arg0  <= dec_arg0;
            cmd_arg1  <= dec_arg1;
        end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ansi_cmd_parser.sv
// Testbench for ansi_cmd_parser: table of byte strings with expected commands,
// scoreboard queue checked on every accepted command, plus hand-written
// latency, backpressure/overflow and mid-sequence reset sequences.
module tb_ansi_cmd_parser;
    typedef struct packed {
        logic [3:0] op;
        logic [7:0] ch;
        logic [6:0] a0;
        logic [6:0] a1;
    } cmd_t;

    typedef struct {
        string name;
        string s;
        int    ncmd;
        cmd_t  e0;
        cmd_t  e1;
        cmd_t  e2;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_char;
    logic [6:0] cmd_arg0;
    logic [6:0] cmd_arg1;
    logic       overflow;

    int   errors = 0;
    int   checks = 0;
    cmd_t exp_q[$];
    cmd_t got, want;
    vec_t vecs[16];

    always #5 clk = ~clk;

    ansi_cmd_parser dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_char(cmd_char), .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1),
        .overflow(overflow)
    );

    function automatic cmd_t mk(input int op, input int ch, input int a0, input int a1);
        cmd_t c;
        c.op = 4'(op);
        c.ch = 8'(ch);
        c.a0 = 7'(a0);
        c.a1 = 7'(a1);
        return c;
    endfunction

    // Scoreboard: every accepted command must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            got = {cmd_op, cmd_char, cmd_arg0, cmd_arg1};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmd got op=%0d ch=%h a0=%0d a1=%0d, none expected",
                         cmd_op, cmd_char, cmd_arg0, cmd_arg1);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL cmd got op=%0d ch=%h a0=%0d a1=%0d want op=%0d ch=%h a0=%0d a1=%0d",
                             cmd_op, cmd_char, cmd_arg0, cmd_arg1, want.op, want.ch, want.a0, want.a1);
                end
            end
        end
    end

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_data  = s[i];
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got %0d commands outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b1;

        vecs[0]  = '{"putc_cr_lf", "A\015\012", 3, mk(0, 8'h41, 0, 0), mk(1, 0, 0, 0), mk(2, 0, 0, 0)};
        vecs[1]  = '{"cup_12_40", "\033[12;40H", 1, mk(4, 0, 11, 39), 0, 0};
        vecs[2]  = '{"cup_home", "\033[H", 1, mk(4, 0, 0, 0), 0, 0};
        vecs[3]  = '{"cup_clamp", "\033[99;200H", 1, mk(4, 0, 29, 79), 0, 0};
        vecs[4]  = '{"move_c5", "\033[5C", 1, mk(7, 8'h43, 5, 0), 0, 0};
        vecs[5]  = '{"move_d", "\033[D", 1, mk(7, 8'h44, 1, 0), 0, 0};
        vecs[6]  = '{"ed", "\033[2J", 1, mk(5, 0, 0, 0), 0, 0};
        vecs[7]  = '{"el", "\033[K", 1, mk(6, 0, 0, 0), 0, 0};
        vecs[8]  = '{"ed_1_none", "\033[1J", 0, 0, 0, 0};
        vecs[9]  = '{"can_abort", "\033[3\030x", 1, mk(0, 8'h78, 0, 0), 0, 0};
`ifdef ANSI_SGR_EN
        vecs[10] = '{"sgr", "\033[32m", 1, mk(8, 0, 32, 0), 0, 0};
`else
        vecs[10] = '{"sgr_off", "\033[32m", 0, 0, 0, 0};
`endif
        vecs[11] = '{"drop_del_c0", "\177\001B\010", 2, mk(0, 8'h42, 0, 0), mk(3, 0, 0, 0), 0};
        vecs[12] = '{"esc_esc_f", "\033\033[1;1f", 1, mk(4, 0, 0, 0), 0, 0};
        vecs[13] = '{"esc_other", "\033xy", 1, mk(0, 8'h79, 0, 0), 0, 0};
        vecs[14] = '{"third_param", "\033[1;2;3H", 1, mk(4, 0, 0, 1), 0, 0};
        vecs[15] = '{"el0_f", "\033[0K\033[7;3f", 2, mk(6, 0, 0, 0), mk(4, 0, 6, 2), 0};

        // Reset state.
        #2;
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_fields", {cmd_op, cmd_char, cmd_arg0, cmd_arg1, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // First-command latency: valid appears two cycles after the strobe.
        exp_q.push_back(mk(0, 8'h41, 0, 0));
        rx_data  = 8'h41;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        check("latency_t1_valid", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        check("latency_t2_valid", 32'(cmd_valid), 32'd1);
        @(posedge clk);
        #1;
        drain("latency");

        for (int v = 0; v < 16; v++) begin
            if (vecs[v].ncmd > 0) exp_q.push_back(vecs[v].e0);
            if (vecs[v].ncmd > 1) exp_q.push_back(vecs[v].e1);
            if (vecs[v].ncmd > 2) exp_q.push_back(vecs[v].e2);
            send_str(vecs[v].s);
            drain(vecs[v].name);
        end
        check("overflow_clear", 32'(overflow), 32'd0);

        // Backpressure: first command holds, four bytes buffered, one dropped.
        cmd_ready = 1'b0;
        exp_q.push_back(mk(0, 8'h61, 0, 0));
        exp_q.push_back(mk(0, 8'h62, 0, 0));
        exp_q.push_back(mk(0, 8'h63, 0, 0));
        exp_q.push_back(mk(0, 8'h64, 0, 0));
        exp_q.push_back(mk(0, 8'h65, 0, 0));
        send_str("abcdef");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_cmd", {cmd_valid, cmd_op, cmd_char, cmd_arg0, cmd_arg1},
                  {1'b1, 4'd0, 8'h61, 7'd0, 7'd0});
        end
        check("overflow_set", 32'(overflow), 32'd1);
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        drain("backpressure");
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a CSI sequence discards it.
        send_str("\033[1");
        reset = 1'b1;
        #1;
        check("async_reset_valid", 32'(cmd_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_clears_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 8'h32, 0, 0));
        exp_q.push_back(mk(0, 8'h48, 0, 0));
        send_str("2H");
        drain("reset_midseq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
